dbg_loader: RTL and testbench

DBG_LOADER -- requirements
Module: dbg_loader

---
 rtl/dbg_pkg.sv | 21 ++
 rtl/dbg_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_dbg_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug instruction-memory loader.
// Optional checksum trailer is enabled by defining DBG_LOADER_CHECKSUM_EN.
package dbg_pkg;

  // The word-count field at the head of every stream is 4 bytes, little-endian.
  localparam int unsigned LEN_BYTES = 4;
  localparam int unsigned LEN_W     = LEN_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
`ifdef DBG_LOADER_CHECKSUM_EN
    , ST_CHK
`endif
  } state_e;

endpackage

// File: rtl/dbg_loader.sv
// dbg_loader: receives a byte stream (4-byte LE word count N, then N LE words)
// and writes each word into cpuCore instruction memory while holding the core
// in reset. The core is released only once a load completes cleanly.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   start            one-cycle load request (honoured in IDLE/DONE/ERROR only)
//   in_valid/in_data byte stream; a byte moves when in_valid && in_ready
//   in_ready         loader can take a byte this cycle
//   dbg_wr_en        one-cycle write strobe, with dbg_addr / dbg_instr
//   core_rst         active-high hold-in-reset, low only in DONE
//   busy, done, err  status flags
//
// Build option: DBG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that
// must match the XOR of every preceding stream byte.
module dbg_loader
  import dbg_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int unsigned     MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            dbg_wr_en,
  output logic [XLEN-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_instr,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned    BYTES     = XLEN / 8;
  localparam int unsigned    BCW       = $clog2(BYTES);
  localparam logic [BCW-1:0] LAST_LANE = BCW'(BYTES - 1);
  localparam logic [BCW-1:0] LEN_LAST  = BCW'(LEN_BYTES - 1);

`ifdef DBG_LOADER_CHECKSUM_EN
  localparam state_e ST_END = ST_CHK;
`else
  localparam state_e ST_END = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [XLEN-1:0]   word_q, word_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef DBG_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              accept;
  logic [LEN_W-1:0]  len_next;
  logic [XLEN-1:0]   word_next;

  // in_ready_q always mirrors the current state, so it is the acceptance qualifier.
  assign accept = in_valid && in_ready_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    len_next   = len_q;
    word_next  = word_q;
`ifdef DBG_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LEN;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          len_d      = '0;
          addr_d     = BASE_ADDR;
`ifdef DBG_LOADER_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end

      ST_LEN: begin
        if (accept) begin
          len_next[{byte_cnt_q[1:0], 3'b000} +: 8] = in_data;
          len_d = len_next;
`ifdef DBG_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          if (byte_cnt_q == LEN_LAST) begin
            byte_cnt_d = '0;
            if (len_next == '0) begin
              state_d = ST_END;
            end else if (len_next > LEN_W'(MAX_WORDS)) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          word_next[{byte_cnt_q, 3'b000} +: 8] = in_data;
          word_d = word_next;
`ifdef DBG_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          if (byte_cnt_q == LAST_LANE) begin
            byte_cnt_d = '0;
            instr_d    = word_next;
            state_d    = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end

      // Strobe is issued during this state; the address advances on exit.
      ST_WRITE: begin
        addr_d     = addr_q + XLEN'(4);
        word_cnt_d = word_cnt_q + LEN_W'(1);
        if ((word_cnt_q + LEN_W'(1)) == len_q) begin
          state_d = ST_END;
        end else begin
          state_d = ST_DATA;
        end
      end

`ifdef DBG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_d = (in_data == chk_q) ? ST_DONE : ST_ERROR;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status/handshake outputs are decoded from the next state and registered.
  always_comb begin
    in_ready_d = 1'b0;
    wr_en_d    = 1'b0;
    core_rst_d = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_d)
      ST_LEN:   begin in_ready_d = 1'b1; busy_d = 1'b1; end
      ST_DATA:  begin in_ready_d = 1'b1; busy_d = 1'b1; end
      ST_WRITE: begin wr_en_d    = 1'b1; busy_d = 1'b1; end
`ifdef DBG_LOADER_CHECKSUM_EN
      ST_CHK:   begin in_ready_d = 1'b1; busy_d = 1'b1; end
`endif
      ST_DONE:  begin done_d     = 1'b1; core_rst_d = 1'b0; end
      ST_ERROR: begin err_d      = 1'b1; end
      default:  begin end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
      instr_q    <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef DBG_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef DBG_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign dbg_wr_en = wr_en_q;
  assign dbg_addr  = addr_q;
  assign dbg_instr = instr_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dbg_loader.sv
// Self-checking bench for dbg_loader. A stream-level model predicts the list of
// instruction-memory writes and the final status of each load; a per-cycle
// monitor checks every write strobe against that list. Directed tests add
// literal expectations for latency, boundaries and reset behaviour.
module tb_dbg_loader;

  localparam int unsigned XLEN = 32;
  localparam int unsigned MAXW = 4;
  localparam logic [31:0] BASE = 32'h0;

  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              dbg_wr_en;
  logic [XLEN-1:0]   dbg_addr;
  logic [XLEN-1:0]   dbg_instr;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  int                tests = 0;
  int                fails = 0;
  wr_t               exp_q[$];
  int                wr_seen = 0;
  logic [31:0]       last_addr = '0;
  logic [31:0]       last_data = '0;
  bit                mon_on = 1'b0;

  dbg_loader #(
    .XLEN     (XLEN),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .dbg_wr_en(dbg_wr_en),
    .dbg_addr (dbg_addr),
    .dbg_instr(dbg_instr),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the next predicted write.
  always @(negedge clk) begin
    if (mon_on) begin
      check("core_rst_vs_done", 32'(core_rst), 32'(!done));
      if (dbg_wr_en) begin
        wr_seen++;
        last_addr = dbg_addr;
        last_data = dbg_instr;
        check("wr_in_ready_low", 32'(in_ready), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", dbg_addr, dbg_instr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", dbg_addr, e.addr);
          check("wr_data", dbg_instr, e.data);
        end
      end
    end
  end

  // Build a stream: LE count, LE words, optional XOR trailer.
  task automatic build(input logic [31:0] n, input logic [31:0] words[$], output byte_t s[$]);
    byte_t x;
    s = {};
    for (int b = 0; b < 4; b++) s.push_back(n[8*b +: 8]);
    foreach (words[i]) for (int b = 0; b < 4; b++) s.push_back(words[i][8*b +: 8]);
`ifdef DBG_LOADER_CHECKSUM_EN
    x = '0;
    foreach (s[i]) x = x ^ s[i];
    s.push_back(x);
`else
    x = '0;
`endif
  endtask

  // Stream-level model: predicted writes and final status.
  task automatic model(input byte_t s[$], output bit e_done, output bit e_err);
    logic [31:0] n;
    n = {s[3], s[2], s[1], s[0]};
    e_done = 1'b0;
    e_err  = 1'b0;
    if (n > MAXW) begin
      e_err = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      wr_t w;
      w.addr = BASE + 32'(4 * i);
      w.data = {s[4*i+7], s[4*i+6], s[4*i+5], s[4*i+4]};
      exp_q.push_back(w);
    end
`ifdef DBG_LOADER_CHECKSUM_EN
    begin
      byte_t x;
      x = '0;
      for (int j = 0; j < 4 + 4 * int'(n); j++) x = x ^ s[j];
      e_done = (s[4 + 4 * int'(n)] == x);
      e_err  = !e_done;
    end
`else
    e_done = 1'b1;
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends bytes [0, upto); returns at the negedge after the last acceptance.
  task automatic send(input byte_t s[$], input bit toggle, input int upto);
    for (int i = 0; i < upto; i++) begin
      bit acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      if (toggle) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      while (!acc) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = s[i];
        acc      = in_ready;
        guard++;
        if (!acc && guard > 50) begin
          tests++;
          fails++;
          $display("FAIL send_timeout: byte %0d never accepted", i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int g;
    g = 0;
    while (!(done || err) && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!(done || err)) begin
      tests++;
      fails++;
      $display("FAIL end_timeout: got busy %0d expected done or err", busy);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(dbg_wr_en), 32'd0);
    check({tag, "_addr"}, dbg_addr, BASE);
    check({tag, "_instr"}, dbg_instr, 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Full load: predict, start, stream, wait, compare final status.
  task automatic run_load(input string tag, input byte_t s[$], input bit toggle);
    bit ed, ee;
    model(s, ed, ee);
    pulse_start();
    send(s, toggle, s.size());
    wait_end();
    check({tag, "_done"}, 32'(done), 32'(ed));
    check({tag, "_err"}, 32'(err), 32'(ee));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    byte_t       s[$];
    logic [31:0] w[$];
    int          w0;
    bit          ed, ee;

    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b1;
    mon_on = 1'b1;

    // Bytes offered in IDLE must not be taken.
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hAA;
    repeat (3) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Single word.
    w = {32'h00108123};
    build(32'd1, w, s);
    w0 = wr_seen;
    run_load("one", s, 1'b0);
    check("one_writes", 32'(wr_seen - w0), 32'd1);
    check("one_addr", last_addr, 32'h0);
    check("one_data", last_data, 32'h00108123);
    check("one_core_rst", 32'(core_rst), 32'd0);

    // Three words with gaps on in_valid.
    w = {32'h11223344, 32'hdeadbeef, 32'h00000013};
    build(32'd3, w, s);
    w0 = wr_seen;
    run_load("three", s, 1'b1);
    check("three_writes", 32'(wr_seen - w0), 32'd3);
    check("three_last_addr", last_addr, 32'h8);
    check("three_last_data", last_data, 32'h00000013);

    // Zero-length load.
    w = {};
    build(32'd0, w, s);
    w0 = wr_seen;
    model(s, ed, ee);
    pulse_start();
    send(s, 1'b0, 4);
`ifndef DBG_LOADER_CHECKSUM_EN
    check("zero_done_latency", 32'(done), 32'd1);
`else
    send(s[4:4], 1'b0, 1);
    wait_end();
`endif
    check("zero_done", 32'(done), 32'(ed));
    check("zero_writes", 32'(wr_seen - w0), 32'd0);

    // One past the limit: error, no writes, then a fresh start works.
    s = {8'd5, 8'd0, 8'd0, 8'd0};
    w0 = wr_seen;
    model(s, ed, ee);
    pulse_start();
    send(s, 1'b0, 4);
    check("over_err", 32'(err), 32'd1);
    check("over_err_model", 32'(err), 32'(ee));
    check("over_core_rst", 32'(core_rst), 32'd1);
    check("over_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("over_writes", 32'(wr_seen - w0), 32'd0);
    pulse_start();
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_in_ready", 32'(in_ready), 32'd1);
    check("restart_err", 32'(err), 32'd0);
    w = {32'h00000093};
    build(32'd1, w, s);
    model(s, ed, ee);
    send(s, 1'b0, s.size());
    wait_end();
    check("restart_done", 32'(done), 32'(ed));
    check("restart_addr", last_addr, 32'h0);

    // Exactly the limit.
    w = {32'h01, 32'h02, 32'h03, 32'h04};
    build(32'(MAXW), w, s);
    w0 = wr_seen;
    run_load("max", s, 1'b0);
    check("max_writes", 32'(wr_seen - w0), 32'd4);
    check("max_last_addr", last_addr, 32'hC);

    // start while busy is ignored.
    w = {32'haabbccdd, 32'h12345678};
    build(32'd2, w, s);
    model(s, ed, ee);
    pulse_start();
    send(s, 1'b0, 6);
    pulse_start();
    check("busy_start_busy", 32'(busy), 32'd1);
    send(s[6:$], 1'b0, s.size() - 6);
    wait_end();
    check("busy_start_done", 32'(done), 32'(ed));
    check("busy_start_data", last_data, 32'h12345678);
    check("busy_start_pending", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset two bytes into word 2.
    w = {32'h0badf00d, 32'hcafebabe, 32'h55aa55aa};
    build(32'd3, w, s);
    w0 = wr_seen;
    model(s, ed, ee);
    pulse_start();
    send(s, 1'b0, 10);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst_writes", 32'(wr_seen - w0), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    w = {32'hcafef00d};
    build(32'd1, w, s);
    run_load("reload", s, 1'b0);
    check("reload_addr", last_addr, BASE);
    check("reload_data", last_data, 32'hcafef00d);

`ifdef DBG_LOADER_CHECKSUM_EN
    // Corrupted trailer -> error with core held.
    w = {32'h00000013, 32'h00100093};
    build(32'd2, w, s);
    s[s.size()-1] = s[s.size()-1] ^ 8'h01;
    run_load("badchk", s, 1'b0);
    check("badchk_err", 32'(err), 32'd1);
    check("badchk_core_rst", 32'(core_rst), 32'd1);
`endif

    repeat (2) @(negedge clk);
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
